// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: data width, bubble encoding, EX misprediction verdicts.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    // EX-stage verdict on the prediction made for the instruction now in EX.
    // 2'b11 is reserved and handled as WP_TAKEN by consumers.
    typedef enum logic [1:0] {
        WP_NONE      = 2'b00,
        WP_NOT_TAKEN = 2'b01,
        WP_TAKEN     = 2'b10
    } wp_e;

    // Sequential successor of a PC, modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC, BTB-hit flag and valid bit.
//  clk_i, rst_ni      clock, async active-low reset
//  flush_i            load a bubble (NOP, pc 0, hit 0, valid 0); beats hold_i
//  hold_i             keep all fields
//  inst_i/pc_i/hit_i  fetch-stage values captured when neither flush nor hold
//  inst_o/pc_o/hit_o/valid_o  registered IF/ID contents
module if_id_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic        hit_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        hit_o,
    output logic        valid_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inst_o  <= NOP_INST;
            pc_o    <= '0;
            hit_o   <= 1'b0;
            valid_o <= 1'b0;
        end else if (flush_i) begin
            inst_o  <= NOP_INST;
            pc_o    <= '0;
            hit_o   <= 1'b0;
            valid_o <= 1'b0;
        end else if (!hold_i) begin
            inst_o  <= inst_i;
            pc_o    <= pc_i;
            hit_o   <= hit_i;
            valid_o <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID register.
//  clk_i, rst_ni            clock, async active-low reset
//  stall_i                  hold PC and IF/ID
//  imem_inst_i              instruction at pc_o (combinational IMEM read)
//  hit_i, predicted_pc_i    BTB lookup result for pc_o
//  wrong_predicted_i        EX verdict (00 ok, 01 should not have been taken, 1x should have been taken)
//  alu_pc_i, pc_ex_i        resolved target and PC of the EX instruction
//  pc_o                     current fetch PC
//  inst_id_o, pc_id_o, hit_id_o, valid_id_o   IF/ID contents
//  flush_o                  combinational: kill ID/EX this cycle
//  redirect_cnt_o, fetch_cnt_o   saturating performance counters
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = rv32i_pkg::NOP_INST,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic [31:0]      imem_inst_i,
    input  logic             hit_i,
    input  logic [31:0]      predicted_pc_i,
    input  logic [1:0]       wrong_predicted_i,
    input  logic [31:0]      alu_pc_i,
    input  logic [31:0]      pc_ex_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      inst_id_o,
    output logic [31:0]      pc_id_o,
    output logic             hit_id_o,
    output logic             valid_id_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] redirect_cnt_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    logic        redirect_c;
    logic        accept_c;
    logic [31:0] pc_next_c;

    assign redirect_c = (wrong_predicted_i != rv32i_pkg::WP_NONE);
    assign accept_c   = !redirect_c && !stall_i;
    assign flush_o    = redirect_c;

    // Next-PC select; a redirect beats a stall because the EX instruction is older.
    always_comb begin
        pc_next_c = rv32i_pkg::pc_plus4(pc_o);
        if (wrong_predicted_i == rv32i_pkg::WP_NOT_TAKEN) begin
            pc_next_c = rv32i_pkg::pc_plus4(pc_ex_i);
        end else if (wrong_predicted_i[1]) begin
            pc_next_c = alu_pc_i;
        end else if (stall_i) begin
            pc_next_c = pc_o;
        end else if (hit_i) begin
            pc_next_c = predicted_pc_i;
        end
    end

    // PC register; low two bits are always cleared on load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_o <= {RESET_PC[31:2], 2'b00};
        end else begin
            pc_o <= {pc_next_c[31:2], 2'b00};
        end
    end

    // Saturating redirect and fetch counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            redirect_cnt_o <= '0;
            fetch_cnt_o    <= '0;
        end else begin
            if (redirect_c && (redirect_cnt_o != '1)) begin
                redirect_cnt_o <= redirect_cnt_o + CNT_W'(1);
            end
            if (accept_c && (fetch_cnt_o != '1)) begin
                fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
            end
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_c),
        .hold_i  (stall_i),
        .inst_i  (imem_inst_i),
        .pc_i    (pc_o),
        .hit_i   (hit_i),
        .inst_o  (inst_id_o),
        .pc_o    (pc_id_o),
        .hit_o   (hit_id_o),
        .valid_o (valid_id_o)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit.
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] IMEM_KEY = 32'hDEAD_0000;

    logic        clk_i;
    logic        rst_ni;
    logic        stall_i;
    logic [31:0] imem_inst_i;
    logic        hit_i;
    logic [31:0] predicted_pc_i;
    logic [1:0]  wrong_predicted_i;
    logic [31:0] alu_pc_i;
    logic [31:0] pc_ex_i;
    logic [31:0] pc_o;
    logic [31:0] inst_id_o;
    logic [31:0] pc_id_o;
    logic        hit_id_o;
    logic        valid_id_o;
    logic        flush_o;
    logic [31:0] redirect_cnt_o;
    logic [31:0] fetch_cnt_o;

    int total;
    int bad;

    fetch_pc_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP),
        .CNT_W    (32)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .stall_i           (stall_i),
        .imem_inst_i       (imem_inst_i),
        .hit_i             (hit_i),
        .predicted_pc_i    (predicted_pc_i),
        .wrong_predicted_i (wrong_predicted_i),
        .alu_pc_i          (alu_pc_i),
        .pc_ex_i           (pc_ex_i),
        .pc_o              (pc_o),
        .inst_id_o         (inst_id_o),
        .pc_id_o           (pc_id_o),
        .hit_id_o          (hit_id_o),
        .valid_id_o        (valid_id_o),
        .flush_o           (flush_o),
        .redirect_cnt_o    (redirect_cnt_o),
        .fetch_cnt_o       (fetch_cnt_o)
    );

    // Instruction memory model: each word encodes its own address.
    assign imem_inst_i = pc_o ^ IMEM_KEY;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; stall_i = 1'b0; hit_i = 1'b0; predicted_pc_i = '0;
        wrong_predicted_i = 2'b00; alu_pc_i = '0; pc_ex_i = '0;
        tick();
        total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=%h", pc_o, 32'h0); end
        total++; if (inst_id_o !== NOP) begin bad++; $display("FAIL rst_inst got=%h exp=%h", inst_id_o, NOP); end
        total++; if (pc_id_o !== 32'h0) begin bad++; $display("FAIL rst_pc_id got=%h exp=0", pc_id_o); end
        total++; if ({hit_id_o, valid_id_o, flush_o} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {hit_id_o, valid_id_o, flush_o}); end
        total++; if (redirect_cnt_o !== 32'h0 || fetch_cnt_o !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%h/%h exp=0/0", redirect_cnt_o, fetch_cnt_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        exp_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc_o, exp_pc); end
            total++; if (valid_id_o !== (i != 0)) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=%b", i, valid_id_o, (i != 0)); end
            tick();
            exp_pc = exp_pc + 32'd4;
        end
        total++; if (pc_o !== 32'h10) begin bad++; $display("FAIL seq_pc_end got=%h exp=10", pc_o); end
        total++; if (pc_id_o !== 32'hC || inst_id_o !== (32'hC ^ IMEM_KEY)) begin bad++; $display("FAIL seq_ifid got=%h/%h exp=0000000c/%h", pc_id_o, inst_id_o, 32'hC ^ IMEM_KEY); end
        total++; if (fetch_cnt_o !== 32'd4) begin bad++; $display("FAIL seq_fetch_cnt got=%0d exp=4", fetch_cnt_o); end
    endtask

    task automatic test_btb_hit();
        hit_i = 1'b1; predicted_pc_i = 32'h40;
        tick();
        hit_i = 1'b0; predicted_pc_i = '0;
        total++; if (pc_o !== 32'h40) begin bad++; $display("FAIL hit_pc got=%h exp=40", pc_o); end
        total++; if (pc_id_o !== 32'h10 || hit_id_o !== 1'b1) begin bad++; $display("FAIL hit_ifid got=%h/%b exp=00000010/1", pc_id_o, hit_id_o); end
        total++; if (inst_id_o !== (32'h10 ^ IMEM_KEY)) begin bad++; $display("FAIL hit_inst got=%h exp=%h", inst_id_o, 32'h10 ^ IMEM_KEY); end
        total++; if (fetch_cnt_o !== 32'd5) begin bad++; $display("FAIL hit_fetch_cnt got=%0d exp=5", fetch_cnt_o); end
    endtask

    task automatic test_redirect_not_taken();
        wrong_predicted_i = 2'b01; pc_ex_i = 32'h40; stall_i = 1'b1;
        #1;
        total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL nt_flush got=%b exp=1", flush_o); end
        tick();
        wrong_predicted_i = 2'b00; pc_ex_i = '0; stall_i = 1'b0;
        #1;
        total++; if (pc_o !== 32'h44) begin bad++; $display("FAIL nt_pc got=%h exp=44", pc_o); end
        total++; if (inst_id_o !== NOP || valid_id_o !== 1'b0 || hit_id_o !== 1'b0 || pc_id_o !== 32'h0) begin bad++; $display("FAIL nt_ifid got=%h/%b/%b/%h exp=%h/0/0/0", inst_id_o, valid_id_o, hit_id_o, pc_id_o, NOP); end
        total++; if (redirect_cnt_o !== 32'd1) begin bad++; $display("FAIL nt_redir_cnt got=%0d exp=1", redirect_cnt_o); end
        total++; if (fetch_cnt_o !== 32'd5) begin bad++; $display("FAIL nt_fetch_cnt got=%0d exp=5", fetch_cnt_o); end
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL nt_flush_clr got=%b exp=0", flush_o); end
    endtask

    task automatic test_redirect_taken();
        wrong_predicted_i = 2'b10; alu_pc_i = 32'h200;
        tick();
        wrong_predicted_i = 2'b00; alu_pc_i = '0;
        total++; if (pc_o !== 32'h200) begin bad++; $display("FAIL tk_pc got=%h exp=200", pc_o); end
        total++; if (valid_id_o !== 1'b0) begin bad++; $display("FAIL tk_valid got=%b exp=0", valid_id_o); end
        tick();
        total++; if (pc_id_o !== 32'h200 || inst_id_o !== (32'h200 ^ IMEM_KEY) || valid_id_o !== 1'b1) begin bad++; $display("FAIL tk_ifid got=%h/%h/%b exp=00000200/%h/1", pc_id_o, inst_id_o, valid_id_o, 32'h200 ^ IMEM_KEY); end
        total++; if (pc_o !== 32'h204 || fetch_cnt_o !== 32'd6) begin bad++; $display("FAIL tk_after got=%h/%0d exp=00000204/6", pc_o, fetch_cnt_o); end
        // Reserved verdict 11 acts as taken, overrides a BTB hit, and the target is word-aligned.
        wrong_predicted_i = 2'b11; alu_pc_i = 32'h303; hit_i = 1'b1; predicted_pc_i = 32'h900;
        tick();
        wrong_predicted_i = 2'b00; alu_pc_i = '0; hit_i = 1'b0; predicted_pc_i = '0;
        total++; if (pc_o !== 32'h300) begin bad++; $display("FAIL wp11_pc got=%h exp=300", pc_o); end
        total++; if (redirect_cnt_o !== 32'd3) begin bad++; $display("FAIL wp11_redir_cnt got=%0d exp=3", redirect_cnt_o); end
        tick();
        total++; if (pc_o !== 32'h304 || pc_id_o !== 32'h300 || fetch_cnt_o !== 32'd7) begin bad++; $display("FAIL wp11_after got=%h/%h/%0d exp=00000304/00000300/7", pc_o, pc_id_o, fetch_cnt_o); end
    endtask

    task automatic test_stall();
        stall_i = 1'b1; hit_i = 1'b1; predicted_pc_i = 32'h800;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pc_o !== 32'h304 || pc_id_o !== 32'h300 || inst_id_o !== (32'h300 ^ IMEM_KEY) || valid_id_o !== 1'b1) begin bad++; $display("FAIL stall_hold[%0d] got=%h/%h/%h/%b exp=00000304/00000300/%h/1", i, pc_o, pc_id_o, inst_id_o, valid_id_o, 32'h300 ^ IMEM_KEY); end
            total++; if (fetch_cnt_o !== 32'd7) begin bad++; $display("FAIL stall_cnt[%0d] got=%0d exp=7", i, fetch_cnt_o); end
        end
        stall_i = 1'b0; hit_i = 1'b0; predicted_pc_i = '0;
        tick();
        total++; if (pc_o !== 32'h308 || pc_id_o !== 32'h304 || fetch_cnt_o !== 32'd8) begin bad++; $display("FAIL stall_resume got=%h/%h/%0d exp=00000308/00000304/8", pc_o, pc_id_o, fetch_cnt_o); end
    endtask

    task automatic test_wrap_and_async_reset();
        wrong_predicted_i = 2'b10; alu_pc_i = 32'hFFFF_FFFC;
        tick();
        wrong_predicted_i = 2'b00; alu_pc_i = '0;
        total++; if (pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_load got=%h exp=fffffffc", pc_o); end
        tick();
        total++; if (pc_o !== 32'h0 || pc_id_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h/%h exp=00000000/fffffffc", pc_o, pc_id_o); end
        tick();
        tick();
        total++; if (pc_o !== 32'h8 || redirect_cnt_o !== 32'd4 || fetch_cnt_o !== 32'd11) begin bad++; $display("FAIL pre_arst got=%h/%0d/%0d exp=00000008/4/11", pc_o, redirect_cnt_o, fetch_cnt_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        total++; if (pc_o !== 32'h0 || inst_id_o !== NOP || pc_id_o !== 32'h0 || valid_id_o !== 1'b0 || hit_id_o !== 1'b0) begin bad++; $display("FAIL arst_state got=%h/%h/%h/%b/%b exp=0/%h/0/0/0", pc_o, inst_id_o, pc_id_o, valid_id_o, hit_id_o, NOP); end
        total++; if (redirect_cnt_o !== 32'h0 || fetch_cnt_o !== 32'h0) begin bad++; $display("FAIL arst_cnt got=%0d/%0d exp=0/0", redirect_cnt_o, fetch_cnt_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        total++; if (pc_o !== 32'h4 || valid_id_o !== 1'b1) begin bad++; $display("FAIL arst_restart got=%h/%b exp=00000004/1", pc_o, valid_id_o); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sequential();
        test_btb_hit();
        test_redirect_not_taken();
        test_redirect_taken();
        test_stall();
        test_wrap_and_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
